// File: rtl/seg7_scan_driver_pkg.sv
// Shared constants for the four-digit 7-segment scan driver.
// Glyphs are active-low {g,f,e,d,c,b,a}.
package seg7_scan_driver_pkg;

  localparam int unsigned NDIGITS = 4;

  localparam logic [NDIGITS-1:0] ANODE_OFF = 4'b1111;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decode.
// Non-BCD codes and an explicit blank request both produce SEG_BLANK.
module seg7_decode
  import seg7_scan_driver_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (digit_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with shadow/active digit banks,
// leading-zero blanking, per-digit decimal point and a dead-time gap per slot.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned DEAD     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_idx,
  input  logic [3:0]         wr_data,
  input  logic               commit,
  input  logic               lzb_en,
  input  logic [NDIGITS-1:0] dp_in,
  output logic [NDIGITS-1:0] an,
  output logic [6:0]         seg,
  output logic               dp_n
);

  localparam int unsigned PW = 16;

  typedef logic [NDIGITS-1:0][3:0] bank_t;

  bank_t              shadow_q, shadow_d;
  bank_t              active_q, active_d;
  logic [PW-1:0]      presc_q, presc_d;
  logic [1:0]         idx_q, idx_d;
  logic [NDIGITS-1:0] an_q, an_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_n_q, dp_n_d;

  logic [3:0]         cur_digit;
  logic [NDIGITS-1:0] lz_blank;
  logic [6:0]         glyph;

  // A write in the same cycle as a commit lands in the committed bank too.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) begin
      shadow_d[wr_idx] = wr_data;
    end
    if (commit) begin
      for (int i = 0; i < int'(NDIGITS); i++) begin
        active_d[i] = (wr_en && (wr_idx == 2'(i))) ? wr_data : shadow_q[i];
      end
    end
  end

  always_comb begin
    presc_d = presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PW'(PRESCALE - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 1'b1;
    end
  end

  // Only exact zeros extend the blanking chain; codes 10..15 break it.
  always_comb begin
    lz_blank[3] = lzb_en && (active_q[3] == 4'h0);
    lz_blank[2] = lz_blank[3] && (active_q[2] == 4'h0);
    lz_blank[1] = lz_blank[2] && (active_q[1] == 4'h0);
    lz_blank[0] = 1'b0;
  end

  assign cur_digit = active_q[idx_q];

  seg7_decode u_decode (
    .digit_i (cur_digit),
    .blank_i (lz_blank[idx_q]),
    .seg_o   (glyph)
  );

  // Unloaded (non-BCD) digits keep their anode off so a fresh display stays
  // dark; zero-blanked digits still drive their anode so the DP can show.
  always_comb begin
    an_d   = ANODE_OFF;
    seg_d  = SEG_BLANK;
    dp_n_d = 1'b1;
    if (presc_q >= PW'(DEAD)) begin
      seg_d  = glyph;
      dp_n_d = ~dp_in[idx_q];
      if (cur_digit <= 4'd9) begin
        an_d[idx_q] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= {NDIGITS{4'hF}};
      active_q <= {NDIGITS{4'hF}};
      presc_q  <= '0;
      idx_q    <= '0;
      an_q     <= ANODE_OFF;
      seg_q    <= SEG_BLANK;
      dp_n_q   <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_n_q   <= dp_n_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp_n = dp_n_q;

endmodule
